psum_accumulator: RTL and testbench

Downstream neighbour of the PE element array: consumes the nine bfloat16 products of one 3×3 PE group per beat. Reduces them through a pipelined adder tree and accumulates the per-beat sums across `cfg_num_ch` input channels. Emits one bf16 partial sum per output pixel on a valid/ready interface toward the activation/pooling stage. Stalls the whole pipeline, and therefore the PE feed, under backpressure.

---
 rtl/vgg_pe_pkg.sv | 27 ++
 rtl/bf16_adder.sv | 105 ++++++++++
 rtl/psum_accumulator.sv | 104 ++++++++++
 tb/tb_psum_accumulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vgg_pe_pkg.sv
`default_nettype none
// =============================================================================
// vgg_pe_pkg : bf16 field layout, special encodings and pipeline tag type
// Rev 1.0
// =============================================================================
package vgg_pe_pkg;

  localparam logic [15:0] BF16_ZERO    = 16'h0000;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [7:0]  BF16_EXP_MAX = 8'd255;

  localparam int BF16_SIGN_BIT = 15;
  localparam int BF16_EXP_MSB  = 14;
  localparam int BF16_EXP_LSB  = 7;
  localparam int BF16_MAN_MSB  = 6;
  localparam int BF16_MAN_LSB  = 0;

  localparam int TREE_LAT = 4;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

endpackage
`default_nettype wire

// File: rtl/bf16_adder.sv
`default_nettype none
// =============================================================================
// bf16_adder : combinational bf16 add, RNE with guard/round/sticky, FTZ
// Rev 1.0
// =============================================================================
module bf16_adder
  import vgg_pe_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic        w_sa, w_sb, w_s_big;
  logic [7:0]  w_ea, w_eb, w_e_big, w_e_small, w_exp_diff, w_shamt;
  logic [6:0]  w_ma, w_mb, w_m_big, w_m_small, w_m_out;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        w_swap, w_res_zero, w_underflow, w_rnd_up;
  logic [10:0] w_big_m, w_aligned, w_norm;
  logic [21:0] w_wide;
  logic [11:0] w_sum;
  logic [3:0]  w_lz;
  logic [9:0]  w_exp, w_exp_rnd;
  logic [8:0]  w_rounded;

  assign w_sa = i_a[BF16_SIGN_BIT];
  assign w_sb = i_b[BF16_SIGN_BIT];
  assign w_ea = i_a[BF16_EXP_MSB:BF16_EXP_LSB];
  assign w_eb = i_b[BF16_EXP_MSB:BF16_EXP_LSB];
  assign w_ma = i_a[BF16_MAN_MSB:BF16_MAN_LSB];
  assign w_mb = i_b[BF16_MAN_MSB:BF16_MAN_LSB];

  // Exponent 0 covers both zero and denormal: denormals flush to zero here.
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_nan  = (w_ea == BF16_EXP_MAX) && (w_ma != 7'd0);
  assign w_b_nan  = (w_eb == BF16_EXP_MAX) && (w_mb != 7'd0);
  assign w_a_inf  = (w_ea == BF16_EXP_MAX) && (w_ma == 7'd0);
  assign w_b_inf  = (w_eb == BF16_EXP_MAX) && (w_mb == 7'd0);

  always_comb begin
    w_swap      = {w_eb, w_mb} > {w_ea, w_ma};
    w_s_big     = w_swap ? w_sb : w_sa;
    w_e_big     = w_swap ? w_eb : w_ea;
    w_e_small   = w_swap ? w_ea : w_eb;
    w_m_big     = w_swap ? w_mb : w_ma;
    w_m_small   = w_swap ? w_ma : w_mb;
    w_exp_diff  = w_e_big - w_e_small;
    w_shamt     = (w_exp_diff > 8'd12) ? 8'd12 : w_exp_diff;
    w_big_m     = {1'b1, w_m_big, 3'b000};
    w_wide      = {1'b1, w_m_small, 3'b000, 11'd0} >> w_shamt;
    // Bits shifted past the guard field collapse into the sticky LSB.
    w_aligned   = {w_wide[21:12], w_wide[11] | (|w_wide[10:0])};
    w_lz        = 4'd0;
    w_underflow = 1'b0;
    w_res_zero  = 1'b0;
    if (w_sa == w_sb) begin
      w_sum = {1'b0, w_big_m} + {1'b0, w_aligned};
      if (w_sum[11]) begin
        w_norm = {w_sum[11:2], w_sum[1] | w_sum[0]};
        w_exp  = {2'b00, w_e_big} + 10'd1;
      end else begin
        w_norm = w_sum[10:0];
        w_exp  = {2'b00, w_e_big};
      end
    end else begin
      w_sum      = {1'b0, w_big_m - w_aligned};
      w_res_zero = (w_sum[10:0] == 11'd0);
      w_lz       = 4'd11;
      for (int i = 0; i < 11; i++) begin
        if (w_sum[i]) w_lz = 4'(10 - i);
      end
      w_norm      = w_sum[10:0] << w_lz;
      w_underflow = ({2'b00, w_e_big} <= {6'd0, w_lz});
      w_exp       = {2'b00, w_e_big} - {6'd0, w_lz};
    end
    w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rounded = {1'b0, w_norm[10:3]} + {8'd0, w_rnd_up};
    w_exp_rnd = w_exp + {9'd0, w_rounded[8]};
    w_m_out   = w_rounded[8] ? w_rounded[7:1] : w_rounded[6:0];
  end

  always_comb begin
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
      o_sum = BF16_QNAN;
    else if (w_a_inf)
      o_sum = {w_sa, BF16_EXP_MAX, 7'd0};
    else if (w_b_inf)
      o_sum = {w_sb, BF16_EXP_MAX, 7'd0};
    else if (w_a_zero && w_b_zero)
      o_sum = BF16_ZERO;
    else if (w_a_zero)
      o_sum = i_b;
    else if (w_b_zero)
      o_sum = i_a;
    else if (w_res_zero || w_underflow)
      o_sum = BF16_ZERO;
    else if (w_exp_rnd >= {2'b00, BF16_EXP_MAX})
      o_sum = {w_s_big, BF16_EXP_MAX, 7'd0};
    else
      o_sum = {w_s_big, w_exp_rnd[7:0], w_m_out};
  end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// =============================================================================
// psum_accumulator : 9-input bf16 adder tree plus channel accumulator, stallable
// Rev 1.0
// =============================================================================
module psum_accumulator
  import vgg_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PROD   = 9,
  parameter int CH_WIDTH   = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PROD*DATA_WIDTH-1:0] in_products,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH_WIDTH-1:0]            cfg_num_ch,
  output logic [DATA_WIDTH-1:0]          out_psum,
  output logic                           out_valid,
  input  logic                           out_ready
);

  logic [DATA_WIDTH-1:0] w_prod [NUM_PROD];
  logic [15:0]           w_l1 [4];
  logic [15:0]           w_l2 [2];
  logic [15:0]           w_l3, w_l4, w_acc_sum, w_acc_in;
  logic [15:0]           r_l1 [5];
  logic [15:0]           r_l2 [3];
  logic [15:0]           r_l3 [2];
  logic [15:0]           r_l4, r_acc;
  logic [DATA_WIDTH-1:0] r_out_psum;
  logic                  r_out_valid;
  beat_tag_t             r_tag [TREE_LAT];
  logic [CH_WIDTH-1:0]   r_ch_cnt, w_last_idx;
  logic                  w_en, w_first, w_last;

  assign w_en       = !r_out_valid || out_ready;
  assign in_ready   = w_en;
  assign out_valid  = r_out_valid;
  assign out_psum   = r_out_psum;
  assign w_last_idx = (cfg_num_ch == '0) ? '0 : cfg_num_ch - CH_WIDTH'(1);
  assign w_first    = (r_ch_cnt == '0);
  // >= rather than == so a counter left beyond a shrunken config still wraps.
  assign w_last     = (r_ch_cnt >= w_last_idx);

  generate
    for (genvar k = 0; k < NUM_PROD; k++) begin : g_unpack
      assign w_prod[k] = in_products[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar k = 0; k < 4; k++) begin : g_l1
      bf16_adder u_add (.i_a(w_prod[2*k]), .i_b(w_prod[2*k+1]), .o_sum(w_l1[k]));
    end
    for (genvar k = 0; k < 2; k++) begin : g_l2
      bf16_adder u_add (.i_a(r_l1[2*k]), .i_b(r_l1[2*k+1]), .o_sum(w_l2[k]));
    end
  endgenerate

  bf16_adder u_add_l3  (.i_a(r_l2[0]), .i_b(r_l2[1]), .o_sum(w_l3));
  bf16_adder u_add_l4  (.i_a(r_l3[0]), .i_b(r_l3[1]), .o_sum(w_l4));
  bf16_adder u_add_acc (.i_a(r_acc),   .i_b(r_l4),    .o_sum(w_acc_sum));

  // First beat of a group loads the tree sum as-is so -0/rounding never leak in.
  assign w_acc_in = r_tag[TREE_LAT-1].first ? r_l4 : w_acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt    <= '0;
      r_acc       <= BF16_ZERO;
      r_out_psum  <= '0;
      r_out_valid <= 1'b0;
      r_l4        <= BF16_ZERO;
      for (int i = 0; i < TREE_LAT; i++) r_tag[i] <= '0;
      for (int i = 0; i < 5; i++) r_l1[i] <= BF16_ZERO;
      for (int i = 0; i < 3; i++) r_l2[i] <= BF16_ZERO;
      for (int i = 0; i < 2; i++) r_l3[i] <= BF16_ZERO;
    end else if (w_en) begin
      if (in_valid) r_ch_cnt <= w_last ? '0 : r_ch_cnt + CH_WIDTH'(1);
      r_tag[0] <= '{valid: in_valid, first: w_first, last: w_last};
      for (int i = 1; i < TREE_LAT; i++) r_tag[i] <= r_tag[i-1];

      for (int i = 0; i < 4; i++) r_l1[i] <= w_l1[i];
      r_l1[4] <= w_prod[NUM_PROD-1];
      r_l2[0] <= w_l2[0];
      r_l2[1] <= w_l2[1];
      r_l2[2] <= r_l1[4];
      r_l3[0] <= w_l3;
      r_l3[1] <= r_l2[2];
      r_l4    <= w_l4;

      r_out_valid <= r_tag[TREE_LAT-1].valid && r_tag[TREE_LAT-1].last;
      if (r_tag[TREE_LAT-1].valid) begin
        if (r_tag[TREE_LAT-1].last) begin
          r_out_psum <= w_acc_in;
          r_acc      <= BF16_ZERO;
        end else begin
          r_acc <= w_acc_in;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// =============================================================================
// tb_psum_accumulator : directed self-checking bench for psum_accumulator
// Rev 1.0
// =============================================================================
module tb_psum_accumulator;

  logic         clk;
  logic         rst_n;
  logic [143:0] in_products;
  logic         in_valid;
  logic         in_ready;
  logic [9:0]   cfg_num_ch;
  logic [15:0]  out_psum;
  logic         out_valid;
  logic         out_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q_res[$];

  psum_accumulator #(.DATA_WIDTH(16), .NUM_PROD(9), .CH_WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_products(in_products),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_num_ch (cfg_num_ch),
    .out_psum   (out_psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] rep9(input logic [15:0] v);
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [143:0] mk2(input logic [15:0] v);
    logic [143:0] r;
    r = '0;
    r[15:0]  = v;
    r[31:16] = v;
    return r;
  endfunction

  function automatic logic [15:0] bp_val(input int i);
    return 16'h3F80 + 16'(i * 16);
  endfunction

  // Handshakes resolved at the next rising edge, sampled after drivers settle.
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready) q_res.push_back(out_psum);
  end

  task automatic run_group(input int nb, input logic [143:0] p,
                           output int lat, output logic [15:0] val);
    lat = -1;
    val = 16'hDEAD;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      in_products = p;
      in_valid    = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        val = out_psum;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] val;
    logic [143:0] p;
    int          sent, guard, lo, found;
    logic        acc;

    rst_n = 1'b0; in_valid = 1'b0; in_products = '0; cfg_num_ch = 10'd1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_psum",  {16'd0, out_psum},  32'h0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;

    // Single beat, nine ones -> 9.0
    q_res.delete();
    run_group(1, rep9(16'h3F80), lat, val);
    chk("single_lat", lat, 5);
    chk("single_val", {16'd0, val}, 32'h4110);
    @(negedge clk);
    chk("single_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("single_count", q_res.size(), 1);

    // Three channels -> 27.0
    cfg_num_ch = 10'd3;
    q_res.delete();
    run_group(3, rep9(16'h3F80), lat, val);
    chk("multi_lat", lat, 5);
    chk("multi_val", {16'd0, val}, 32'h41D8);
    repeat (2) @(negedge clk);
    chk("multi_count", q_res.size(), 1);

    // Backpressure: ten distinct beats, 8-cycle stall on the first result
    cfg_num_ch = 10'd1;
    q_res.delete();
    sent = 0; guard = 0; lo = 0; found = 0;
    fork
      begin
        @(negedge clk);
        in_products = mk2(bp_val(0));
        in_valid    = 1'b1;
        while (sent < 10 && guard < 200) begin
          guard++;
          #2;
          acc = in_ready;
          @(negedge clk);
          if (acc) begin
            sent++;
            if (sent < 10) in_products = mk2(bp_val(sent));
            else in_valid = 1'b0;
          end
        end
      end
      begin
        for (int k = 0; k < 100 && found == 0; k++) begin
          @(negedge clk);
          if (out_valid) found = 1;
        end
        if (found == 1) begin
          out_ready = 1'b0;
          for (int k = 0; k < 8; k++) begin
            #2;
            if (!in_ready) lo++;
            @(negedge clk);
          end
          out_ready = 1'b1;
        end
      end
    join
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_sent", sent, 10);
    chk("bp_stall_in_ready_low", lo, 8);
    chk("bp_count", q_res.size(), 10);
    for (int i = 0; i < 10; i++) begin
      val = (i < q_res.size()) ? q_res[i] : 16'hDEAD;
      chk($sformatf("bp_res%0d", i), {16'd0, val}, {16'd0, bp_val(i) + 16'h0080});
    end

    // Special values
    p = rep9(16'h0000);
    for (int k = 0; k < 4; k++) p[16*k +: 16] = 16'h4000;
    for (int k = 4; k < 8; k++) p[16*k +: 16] = 16'hC000;
    run_group(1, p, lat, val);
    chk("spec_cancel", {16'd0, val}, 32'h0000);
    p = rep9(16'h3F80);
    p[15:0]  = 16'h7F80;
    p[31:16] = 16'hFF80;
    run_group(1, p, lat, val);
    chk("spec_inf_nan", {16'd0, val}, 32'h7FC0);
    p = rep9(16'h0000);
    p[15:0] = 16'h0001;
    run_group(1, p, lat, val);
    chk("spec_denorm", {16'd0, val}, 32'h0000);
    chk("spec_denorm_lat", lat, 5);

    // Zero config behaves as one channel
    cfg_num_ch = 10'd0;
    q_res.delete();
    run_group(1, rep9(16'h3F80), lat, val);
    chk("zcfg_val", {16'd0, val}, 32'h4110);
    chk("zcfg_lat", lat, 5);

    // Reset in the middle of a 4-channel group
    cfg_num_ch = 10'd4;
    repeat (2) begin
      @(negedge clk);
      in_products = rep9(16'h3F80);
      in_valid    = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_psum",  {16'd0, out_psum},  32'h0);
    rst_n = 1'b1;
    q_res.delete();
    run_group(4, rep9(16'h3F80), lat, val);
    chk("midrst_val", {16'd0, val}, 32'h4210);
    chk("midrst_lat", lat, 5);
    repeat (8) @(negedge clk);
    chk("midrst_count", q_res.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
